// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: round-robin grant into an operand
// stage (S1), ALU result captured in a response stage (S2). ALU_ARB_FIXED_PRIO_EN selects strict priority for requester 0.
module alu_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req0_shamt,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic        alu_ovf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_ne,
  output logic        rsp_lt,
  output logic        rsp_ovf
);

  typedef struct packed {
    logic [4:0]  opcode;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
  } aluReq_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
  } aluRsp_t;

  aluReq_t [1:0] reqIn;
  aluReq_t       s1Req;
  logic          s1Id;
  aluRsp_t       s2Rsp;
  logic [2:1]    vldPipe;  // [1] = S1 occupied, [2] = S2 occupied
  logic          anyReq;
  logic          gntId;
  logic          s2Load;
  logic          s1Accept;

  assign reqIn[0] = {req0_opcode, req0_shamt, req0_a, req0_b};
  assign reqIn[1] = {req1_opcode, req1_shamt, req1_a, req1_b};

  assign anyReq   = req0_valid | req1_valid;
  assign s2Load   = vldPipe[1] && (!vldPipe[2] || rsp_ready);
  // reset gates acceptance so ready stays low for the whole reset window
  assign s1Accept = reset && (!vldPipe[1] || s2Load) && anyReq;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gntId = !req0_valid;
`else
  logic lastGrant;

  // on a tie, favour whoever did not transfer last
  assign gntId = (req0_valid && req1_valid) ? !lastGrant : !req0_valid;

  always_ff @(posedge clock) begin
    if (!reset)        lastGrant <= 1'b1;
    else if (s1Accept) lastGrant <= gntId;
  end
`endif

  assign req0_ready = s1Accept && !gntId;
  assign req1_ready = s1Accept &&  gntId;

  always_ff @(posedge clock) begin
    if (!reset) begin
      vldPipe <= '0;
      s1Req   <= '0;
      s1Id    <= 1'b0;
      s2Rsp   <= '0;
    end else begin
      if (s2Load) begin
        vldPipe[2] <= 1'b1;
        s2Rsp      <= '{id: s1Id, result: alu_result, ne: alu_ne, lt: alu_lt, ovf: alu_ovf};
      end else if (rsp_ready) begin
        vldPipe[2] <= 1'b0;
      end
      if (s1Accept) begin
        vldPipe[1] <= 1'b1;
        s1Req      <= reqIn[gntId];
        s1Id       <= gntId;
      end else if (s2Load) begin
        vldPipe[1] <= 1'b0;
      end
    end
  end

  assign {alu_opcode, alu_shamt, alu_opA, alu_opB} = vldPipe[1] ? s1Req : '0;

  assign rsp_valid  = vldPipe[2];
  assign rsp_id     = s2Rsp.id;
  assign rsp_result = s2Rsp.result;
  assign rsp_ne     = s2Rsp.ne;
  assign rsp_lt     = s2Rsp.lt;
  assign rsp_ovf    = s2Rsp.ovf;

  always_comb begin
    assert (!(req0_ready && req1_ready));
  end

  aRspHold: assert property (@(posedge clock) disable iff (!reset)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(s2Rsp)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stand-in combinational ALU and an
// in-order response scoreboard.
module tb_alu_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_opcode = '0, req0_shamt = '0, req1_opcode = '0, req1_shamt = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode, alu_shamt;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_ovf;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  int nVec = 0, nMis = 0, cyc = 0, nPop = 0, firstPop = -1, lastPop = -1;
  logic xfer0, xfer1;
  logic [35:0] expQ[$];

  always #5 clock = ~clock;

  alu_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_ne(rsp_ne), .rsp_lt(rsp_lt), .rsp_ovf(rsp_ovf)
  );

  // stand-in ALU: 0 ADD, 1 SUB (sets lt), 2 SLL by shamt, 3 AND, else XOR
  function automatic logic [34:0] aluRef(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic lt, ovf;
    r = a ^ b; lt = 1'b0; ovf = 1'b0;
    case (op)
      5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]);
                  lt = $signed(a) < $signed(b); end
      5'd2: r = a << sh;
      5'd3: r = a & b;
      default: ;
    endcase
    return {r, a != b, lt, ovf};
  endfunction

  assign {alu_result, alu_ne, alu_lt, alu_ovf} = aluRef(alu_opcode, alu_shamt, alu_opA, alu_opB);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: record transfers, score a consumed response, advance to edge+1
  task automatic tick();
    logic [35:0] e;
    #1;
    xfer0 = req0_valid && req0_ready;
    xfer1 = req1_valid && req1_ready;
    if (xfer0) expQ.push_back({1'b0, aluRef(req0_opcode, req0_shamt, req0_a, req0_b)});
    if (xfer1) expQ.push_back({1'b1, aluRef(req1_opcode, req1_shamt, req1_a, req1_b)});
    if (reset && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = expQ.pop_front();
        chk("rsp_order", {rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf}, e);
      end
      nPop++;
      if (firstPop < 0) firstPop = cyc;
      lastPop = cyc;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    expQ.delete();
    nPop = 0; firstPop = -1; lastPop = -1;
  endtask

  task automatic drain(input string tag, input int expPops);
    for (int k = 0; k < 10 && expQ.size() != 0; k++) tick();
    chk({tag, "_empty"}, expQ.size(), 0);
    chk({tag, "_pops"}, nPop, expPops);
  endtask

  initial begin
    // reset values, with a request already pending
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
    tick(); tick();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf}, 0);
    chk("rst_alu", {alu_opcode, alu_shamt, alu_opA, alu_opB}, 0);

    // single ADD 5+7 from requester 0
    reset = 1'b1;
    #1;
    chk("single_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("single_aluA", alu_opA, 32'd5);
    chk("single_aluB", alu_opB, 32'd7);
    chk("single_s1_no_rsp", rsp_valid, 0);
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp", {rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf}, {1'b0, 32'd12, 3'b100});
    tick();
    chk("single_rsp_done", rsp_valid, 0);

    // signed overflow from requester 1
    req1_valid = 1'b1; req1_opcode = 5'd0; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1;
    #1;
    chk("ovf_rdy", {req0_ready, req1_ready}, 2'b01);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("ovf_rsp", {rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf},
        {2'b11, 32'h8000_0000, 3'b101});
    tick();

    // tie: alternation 0,1,0,1 and back-to-back responses
    doReset();
    req0_valid = 1'b1; req0_opcode = 5'd1; req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1'b1; req1_opcode = 5'd2; req1_a = 32'd1; req1_b = 32'd9; req1_shamt = 5'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("tie_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (xfer0) req0_a = req0_a + 32'd1;
      if (xfer1) req1_shamt = req1_shamt + 5'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("tie", 4);
    chk("tie_back_to_back", lastPop - firstPop, 3);

    // backpressure with S2 and S1 both occupied
    doReset();
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd1; req0_b = 32'd2;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_opcode = 5'd3; req1_a = 32'hF0F0; req1_b = 32'h0FF0;
    tick();
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd100; req0_b = 32'd200;
    req1_valid = 1'b1; req1_opcode = 5'd1; req1_a = 32'd3; req1_b = 32'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", {req0_ready, req1_ready}, 2'b00);
      chk("bp_rsp", {rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf},
          {2'b10, 32'd3, 3'b100});
      chk("bp_s1_hold", alu_opA, 32'hF0F0);
      tick();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 6 && (req0_valid || req1_valid); k++) begin
      tick();
      if (xfer0) req0_valid = 1'b0;
      if (xfer1) req1_valid = 1'b0;
    end
    drain("bp", 4);

    // reset the cycle after an accept: nothing may emerge
    doReset();
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd5; req0_b = 32'd7;
    tick();
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();
    expQ.delete();
    req1_valid = 1'b1;
    #1;
    chk("midrst_rdy1", req1_ready, 0);
    chk("midrst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf}, 0);
    chk("midrst_alu", {alu_opcode, alu_shamt, alu_opA, alu_opB}, 0);
    req1_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_no_rsp", rsp_valid, 0);
    end

    // three ops with both requesters valid
    doReset();
    req0_valid = 1'b1; req0_opcode = 5'd0; req0_a = 32'd40; req0_b = 32'd2;
    req1_valid = 1'b1; req1_opcode = 5'd4; req1_a = 32'hAA; req1_b = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("prio_grant", {req0_ready, req1_ready}, 2'b10);
`else
      chk("prio_grant", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
`endif
      tick();
      if (xfer0) req0_a = req0_a + 32'd1;
      if (xfer1) req1_a = req1_a + 32'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("prio", 3);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be synchronous and active-low.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset; 0 at a rising clock edge resets the block.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-006 reqN_opcode  input  5  ALU opcode for requester n; reqN_shamt  input  5  shift amount.
REQ-007 reqN_a / reqN_b  input  32  operands A and B for requester n.
REQ-008 alu_opA / alu_opB  output  32  operands to the shared ALU; alu_opcode / alu_shamt  output  5.
REQ-009 alu_result  input  32  ALU result; alu_ne / alu_lt / alu_ovf  input  1  ALU isNotEqual, isLessThan and overflow outputs.
REQ-010 rsp_valid  output  1  a response is held; rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  requester that issued the held response.
REQ-012 rsp_result  output  32  result; rsp_ne / rsp_lt / rsp_ovf  output  1  flags, all captured from the ALU.

Function
REQ-013 Pipeline SHALL have two stages: S1 (operand register feeding the ALU) and S2 (response register); each stage has a valid bit.
REQ-014 alu_opA/opB/opcode/shamt SHALL always equal the S1 register contents, and SHALL be 0 when S1 is empty.
REQ-015 S2 SHALL load when S1 is valid and (!rsp_valid || rsp_ready), capturing alu_result, the flags and the S1 id.
REQ-016 S1 SHALL accept when (!S1 valid || S2 loads) and a grant exists; reqN_ready SHALL be 1 only for the granted requester and only when S1 accepts.
REQ-017 Transfer SHALL occur when reqN_valid && reqN_ready; at most one requester transfers per cycle.
REQ-018 Latency SHALL be 2 cycles: transfer at edge N gives rsp_valid=1 after edge N+1 when not backpressured.
REQ-019 Throughput SHALL be one op per cycle when rsp_ready stays 1.
REQ-020 Arbitration SHALL be round-robin: a single valid requester is granted; when both are valid, grant SHALL go to the requester not in last_grant.
REQ-021 last_grant SHALL update only on a transfer, never on a grant without transfer.
REQ-022 When rsp_valid && !rsp_ready, all rsp_* outputs SHALL hold stable, and S1 SHALL hold while full.
REQ-023 Opcode SHALL pass to the ALU unmodified; the block SHALL NOT decode or reject opcodes.
REQ-024 Response order SHALL equal acceptance order; no operation SHALL be dropped or duplicated.

Reset
REQ-025 While reset=0: S1 valid=0, rsp_valid=0, reqN_ready=0, rsp_id=0, rsp_result=0, all rsp flags=0, alu_* outputs=0, last_grant=1.
REQ-026 With last_grant=1 at reset, requester 0 SHALL win the first tie.
REQ-027 Reset asserted mid-operation SHALL discard in-flight S1/S2 contents with no response issued.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL have strict priority and last_grant SHALL be unused.
REQ-029 When ALU_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-020 SHALL apply; this is the default.

Verification
REQ-030 Single op: req0 ADD (opcode 0), a=5, b=7 -> two cycles later rsp_valid=1, rsp_id=0, rsp_result=12, ne=1, lt=0, ovf=0.
REQ-031 Tie: both valid for 4 consecutive accepted ops -> grant order 0,1,0,1, responses in the same order, one per cycle.
REQ-032 Backpressure: rsp_ready=0 for 3 cycles with an op in S2 -> rsp_* stable, S1 fills, both reqN_ready=0; rsp_ready=1 -> resumes with no loss.
REQ-033 Overflow: req1 ADD a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_ovf=1, rsp_id=1.
REQ-034 Reset at the cycle after an accept -> no response on rsp after reset release, all outputs at reset values.
REQ-035 With ALU_ARB_FIXED_PRIO_EN defined, both valid for 3 ops -> all three granted to requester 0, req1 stalls.
